iob_vexriscv_dbus_bridge: RTL and testbench
===========================================

IOB_VEXRISCV_DBUS_BRIDGE -- requirements
Module: iob_vexriscv_dbus_bridge

Interface
REQ-001 Parameters SHALL be: ADDR_W, 32, byte address width; DATA_W, 32, data width (32 or 64); CMD_DEPTH, 4, command FIFO depth (power of 2, 2..16).
REQ-002 Ports SHALL be: clk  in  1  single clock, all logic on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 cmd_valid  in  1  CPU data command valid; cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
REQ-005 cmd_wr  in  1  write=1/read=0; cmd_size  in  2  log2 access bytes; cmd_addr  in  ADDR_W  byte address; cmd_wdata  in  DATA_W  write data, CPU-replicated.
REQ-006 rsp_valid  out  1  read response pulse; rsp_data  out  DATA_W  read word; rsp_error  out  1  response error.
REQ-007 m_valid  out  1  IOb native request; m_addr  out  ADDR_W; m_wdata  out  DATA_W; m_wstrb  out  DATA_W/8  (all zero = read).
REQ-008 m_ready  in  1  one-cycle completion pulse; m_rdata  in  DATA_W  valid when m_ready.
REQ-009 align_err  out  1  sticky misaligned-access flag.

Function
REQ-010 Commands SHALL be pushed into a CMD_DEPTH-entry FIFO; cmd_ready SHALL equal not-full, with no same-cycle bypass (push refused when full even if a pop occurs that cycle).
REQ-011 Simultaneous push and pop when not full SHALL leave occupancy unchanged; pointers SHALL wrap modulo CMD_DEPTH.
REQ-012 FSM states SHALL be IDLE and REQ; IDLE->REQ when FIFO non-empty; REQ->REQ on m_ready if FIFO still non-empty after pop; REQ->IDLE on m_ready if empty.
REQ-013 m_valid SHALL be high exactly in REQ; m_addr, m_wdata, m_wstrb SHALL come from the FIFO head and stay stable until m_ready.
REQ-014 Earliest m_valid SHALL be the cycle after command acceptance.
REQ-015 m_addr SHALL be cmd_addr with its low log2(DATA_W/8) bits cleared; m_wdata SHALL be cmd_wdata unchanged.
REQ-016 For writes m_wstrb SHALL be ((1<<(1<<size))-1) shifted left by the byte offset, truncated to DATA_W/8 bits; size above log2(DATA_W/8) SHALL be clamped to full width; reads SHALL drive m_wstrb=0.
REQ-017 On m_ready for a read, rsp_valid SHALL pulse high for one cycle on the following cycle with rsp_data = registered m_rdata (unshifted) and rsp_error=0.
REQ-018 Writes SHALL produce no rsp_valid.
REQ-019 Responses SHALL be returned strictly in command order.
REQ-020 m_ready received in IDLE SHALL be ignored.

Reset
REQ-021 While rst_n low: FIFO empty, state IDLE, cmd_ready=0, m_valid=0, m_wstrb=0, rsp_valid=0, rsp_error=0, align_err=0, rsp_data=0, m_addr=0, m_wdata=0.
REQ-022 Assertion mid-transaction SHALL clear all state immediately (m_valid falls asynchronously), discarding queued commands; cmd_ready SHALL rise the first clock edge after rst_n deasserts.

Configuration
REQ-023 Macro VEXRISCV_DBUS_ALIGN_CHK_EN SHALL enable alignment checking: an entry whose address is not a multiple of its access size SHALL be popped without raising m_valid, set align_err, and, if a read, pulse rsp_valid with rsp_error=1, rsp_data=0 one cycle later; if a write, be dropped.
REQ-024 Without the macro, no check SHALL exist: misaligned entries are issued per REQ-015/016, rsp_error and align_err tied 0.

Verification
REQ-025 Read word at 0x100, m_ready 2 cycles after m_valid, m_rdata=0xDEADBEEF -> m_addr=0x100, m_wstrb=0, rsp_valid one cycle after m_ready, rsp_data=0xDEADBEEF.
REQ-026 Byte write, size=0, addr=0x103, wdata=0x5A5A5A5A -> m_addr=0x100, m_wstrb=4'b1000, no rsp_valid; halfword at 0x102 -> m_wstrb=4'b1100.
REQ-027 m_ready held low, push 5 commands with CMD_DEPTH=4 -> cmd_ready low after 4th; 5th accepted the cycle after the first m_ready; issue order preserved.
REQ-028 Back-to-back reads A,B,C with m_ready every cycle -> m_valid continuously high 3 cycles, rsp_data returns A,B,C in order.
REQ-029 Drop rst_n while m_valid high with 2 queued -> m_valid falls without clock edge; after release no m_valid, FIFO empty.
REQ-030 With VEXRISCV_DBUS_ALIGN_CHK_EN, word read at 0x102 -> no m_valid, rsp_valid with rsp_error=1, align_err=1 until reset; without macro -> m_addr=0x100, rsp_error=0.

Source files
------------

// File: rtl/iob_vexriscv_dbus_bridge.sv
// VexRiscv data-bus to IOb native bridge: queues CPU commands in a FIFO and issues them one at a time.
// Optional alignment checking is enabled with `define VEXRISCV_DBUS_ALIGN_CHK_EN.
module iob_vexriscv_dbus_bridge #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int CMD_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_wr,
    input  logic [1:0]            cmd_size,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_data,
    output logic                  rsp_error,
    output logic                  m_valid,
    output logic [ADDR_W-1:0]     m_addr,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [DATA_W/8-1:0]   m_wstrb,
    input  logic                  m_ready,
    input  logic [DATA_W-1:0]     m_rdata,
    output logic                  align_err
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int PTR_W = $clog2(CMD_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {IDLE, REQ} state_t;
    state_t state, state_n;

    logic [ADDR_W-1:0] mem_addr  [CMD_DEPTH];
    logic [DATA_W-1:0] mem_wdata [CMD_DEPTH];
    logic [NB-1:0]     mem_wstrb [CMD_DEPTH];
    logic              mem_wr    [CMD_DEPTH];

    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count;
    logic             rdy_en;
    logic             full, empty, push, pop;
    logic             head_wr, next_avail, rd_done;
    logic             head_mis, next_mis, push_mis;
    logic [1:0]       sz_c;
    logic [2*NB-1:0]  lane_mask, lane_shift;
    logic [NB-1:0]    push_wstrb;
    logic [ADDR_W-1:0] push_addr;

    assign full      = (count == CNT_W'(CMD_DEPTH));
    assign empty     = (count == '0);
    assign cmd_ready = rdy_en && !full;
    assign push      = cmd_valid && cmd_ready;
    assign head_wr   = mem_wr[rd_ptr];
    assign next_avail = (count > CNT_W'(1)) || push;
    assign rd_done   = (state == REQ) && m_ready && !head_wr;

    // Oversized accesses clamp to the full bus width.
    always_comb begin
        sz_c       = (cmd_size > 2'(OFF_W)) ? 2'(OFF_W) : cmd_size;
        lane_mask  = ((2*NB)'(1) << (1 << sz_c)) - (2*NB)'(1);
        lane_shift = lane_mask << cmd_addr[OFF_W-1:0];
        push_wstrb = cmd_wr ? lane_shift[NB-1:0] : '0;
        push_addr  = {cmd_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
    end

`ifdef VEXRISCV_DBUS_ALIGN_CHK_EN
    logic mem_mis [CMD_DEPTH];
    logic err_rsp;
    logic align_q, rsp_error_q;

    assign push_mis  = (cmd_addr[OFF_W-1:0] & OFF_W'((1 << sz_c) - 1)) != '0;
    assign head_mis  = mem_mis[rd_ptr];
    assign next_mis  = (count > CNT_W'(1)) ? mem_mis[rd_ptr + PTR_W'(1)] : push_mis;
    assign err_rsp   = (state == IDLE) && pop && !head_wr;
    assign align_err = align_q;
    assign rsp_error = rsp_error_q;

    always_ff @(posedge clk) begin
        if (push) mem_mis[wr_ptr] <= push_mis;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            align_q     <= 1'b0;
            rsp_error_q <= 1'b0;
        end else begin
            if ((state == IDLE) && pop) align_q <= 1'b1;
            if (err_rsp) rsp_error_q <= 1'b1;
            else if (rd_done) rsp_error_q <= 1'b0;
        end
    end
`else
    assign push_mis  = 1'b0;
    assign head_mis  = 1'b0;
    assign next_mis  = 1'b0;
    assign align_err = 1'b0;
    assign rsp_error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr]  <= push_addr;
            mem_wdata[wr_ptr] <= cmd_wdata;
            mem_wstrb[wr_ptr] <= push_wstrb;
            mem_wr[wr_ptr]    <= cmd_wr;
        end
    end

    // A push into an empty FIFO goes straight to REQ so m_valid follows acceptance by one cycle.
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    if (head_mis) pop = 1'b1;
                    else state_n = REQ;
                end else if (push && !push_mis) begin
                    state_n = REQ;
                end
            end
            REQ: begin
                if (m_ready) begin
                    pop     = 1'b1;
                    state_n = (next_avail && !next_mis) ? REQ : IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            rdy_en <= 1'b0;
        end else begin
            state  <= state_n;
            rdy_en <= 1'b1;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if (rd_done) begin
                rsp_valid <= 1'b1;
                rsp_data  <= m_rdata;
            end
`ifdef VEXRISCV_DBUS_ALIGN_CHK_EN
            else if (err_rsp) begin
                rsp_valid <= 1'b1;
                rsp_data  <= '0;
            end
`endif
        end
    end

    // Gating by m_valid keeps the request bus at zero during reset and idle.
    assign m_valid = (state == REQ);
    assign m_addr  = m_valid ? mem_addr[rd_ptr]  : '0;
    assign m_wdata = m_valid ? mem_wdata[rd_ptr] : '0;
    assign m_wstrb = m_valid ? mem_wstrb[rd_ptr] : '0;

endmodule

// File: tb/tb_iob_vexriscv_dbus_bridge.sv
// Directed bench for iob_vexriscv_dbus_bridge: vector table plus FIFO-full, back-to-back and reset sequences.
module tb_iob_vexriscv_dbus_bridge;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_wr = 1'b0;
    logic [1:0]  cmd_size = 2'd0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_error;
    logic        m_valid;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_ready = 1'b0;
    logic [31:0] m_rdata = '0;
    logic        align_err;

    int total = 0;
    int pass  = 0;

    iob_vexriscv_dbus_bridge #(.ADDR_W(32), .DATA_W(32), .CMD_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr), .cmd_size(cmd_size),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error),
        .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_ready(m_ready), .m_rdata(m_rdata), .align_err(align_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        logic [3:0]  exp_wstrb;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after an edge; returns just after the edge that accepted the command.
    task automatic send_cmd(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] wdata);
        int n = 0;
        cmd_valid = 1'b1; cmd_wr = wr; cmd_size = size; cmd_addr = addr; cmd_wdata = wdata;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        if (!cmd_ready) check("cmd_accept_timeout", 0, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    function automatic vec_t mk(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                input logic [31:0] exp_addr, input logic [3:0] exp_wstrb);
        vec_t v;
        v.wr = wr; v.size = size; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.exp_addr = exp_addr; v.exp_wstrb = exp_wstrb;
        return v;
    endfunction

    initial begin
        vecs.push_back(mk(1'b0, 2'd2, 32'h100, 32'h0,        32'hDEADBEEF, 32'h100, 4'b0000));
        vecs.push_back(mk(1'b1, 2'd0, 32'h103, 32'h5A5A5A5A, 32'h0,        32'h100, 4'b1000));
        vecs.push_back(mk(1'b1, 2'd1, 32'h102, 32'hA5A5A5A5, 32'h0,        32'h100, 4'b1100));
        vecs.push_back(mk(1'b1, 2'd0, 32'h201, 32'h11111111, 32'h0,        32'h200, 4'b0010));
        vecs.push_back(mk(1'b1, 2'd2, 32'h040, 32'hCAFEF00D, 32'h0,        32'h040, 4'b1111));
        vecs.push_back(mk(1'b1, 2'd3, 32'h080, 32'h01234567, 32'h0,        32'h080, 4'b1111));
        vecs.push_back(mk(1'b0, 2'd0, 32'h305, 32'h0,        32'h12345678, 32'h304, 4'b0000));
`ifndef VEXRISCV_DBUS_ALIGN_CHK_EN
        vecs.push_back(mk(1'b0, 2'd2, 32'h102, 32'h0,        32'h87654321, 32'h100, 4'b0000));
        vecs.push_back(mk(1'b1, 2'd1, 32'h101, 32'h2222AAAA, 32'h0,        32'h100, 4'b0110));
`endif

        // Reset values while rst_n is held low
        tick();
        tick();
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_wstrb", m_wstrb, 0);
        check("rst_m_addr", m_addr, 0);
        check("rst_m_wdata", m_wdata, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_error", rsp_error, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_align_err", align_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rdy_before_edge", cmd_ready, 0);
        tick();
        check("rdy_after_edge", cmd_ready, 1);

        // Vector table: issue, hold m_ready low one cycle, complete, check response
        foreach (vecs[i]) begin
            send_cmd(vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wdata);
            check($sformatf("v%0d_m_valid", i), m_valid, 1);
            check($sformatf("v%0d_m_addr", i), m_addr, vecs[i].exp_addr);
            check($sformatf("v%0d_m_wstrb", i), m_wstrb, vecs[i].exp_wstrb);
            check($sformatf("v%0d_m_wdata", i), m_wdata, vecs[i].wdata);
            tick();
            check($sformatf("v%0d_m_addr_hold", i), m_addr, vecs[i].exp_addr);
            m_ready = 1'b1;
            m_rdata = vecs[i].rdata;
            tick();
            m_ready = 1'b0;
            check($sformatf("v%0d_rsp_valid", i), rsp_valid, !vecs[i].wr);
            if (!vecs[i].wr) begin
                check($sformatf("v%0d_rsp_data", i), rsp_data, vecs[i].rdata);
                check($sformatf("v%0d_rsp_error", i), rsp_error, 0);
            end
            check($sformatf("v%0d_m_valid_done", i), m_valid, 0);
            check($sformatf("v%0d_align_err", i), align_err, 0);
            tick();
            check($sformatf("v%0d_rsp_pulse", i), rsp_valid, 0);
        end

        // m_ready in IDLE does nothing
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check("idle_ready_m_valid", m_valid, 0);
        check("idle_ready_rsp_valid", rsp_valid, 0);
        check("idle_ready_cmd_ready", cmd_ready, 1);

        // FIFO full: 4 queued, 5th waits until the cycle after the first m_ready
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_size = 2'd2;
        for (int i = 0; i < 4; i++) begin
            cmd_addr = 32'h400 + 32'(i) * 32'h10;
            cmd_wdata = 32'(i);
            check($sformatf("fill%0d_cmd_ready", i), cmd_ready, 1);
            tick();
        end
        check("full_cmd_ready", cmd_ready, 0);
        cmd_addr = 32'h440; cmd_wdata = 32'd4;
        tick();
        check("full_hold_cmd_ready", cmd_ready, 0);
        check("full_head", m_addr, 32'h400);
        m_ready = 1'b1;
        check("no_bypass_cmd_ready", cmd_ready, 0);
        tick();
        m_ready = 1'b0;
        check("after_pop_cmd_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        for (int k = 1; k < 5; k++) begin
            check($sformatf("order%0d_m_valid", k), m_valid, 1);
            check($sformatf("order%0d_m_addr", k), m_addr, 32'h400 + 32'(k) * 32'h10);
            m_ready = 1'b1;
            tick();
            m_ready = 1'b0;
        end
        check("drain_m_valid", m_valid, 0);
        check("drain_rsp_valid", rsp_valid, 0);

        // Back-to-back reads with m_ready every cycle
        for (int k = 0; k < 3; k++) send_cmd(1'b0, 2'd2, 32'h500 + 32'(k) * 4, 32'h0);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("b2b%0d_m_valid", k), m_valid, 1);
            check($sformatf("b2b%0d_m_addr", k), m_addr, 32'h500 + 32'(k) * 4);
            m_ready = 1'b1;
            m_rdata = 32'hA0A0_0000 + 32'(k);
            tick();
            check($sformatf("b2b%0d_rsp_valid", k), rsp_valid, 1);
            check($sformatf("b2b%0d_rsp_data", k), rsp_data, 32'hA0A0_0000 + 32'(k));
        end
        m_ready = 1'b0;
        check("b2b_end_m_valid", m_valid, 0);
        tick();
        check("b2b_end_rsp_valid", rsp_valid, 0);

`ifdef VEXRISCV_DBUS_ALIGN_CHK_EN
        // Misaligned read returns an error response; misaligned write is dropped
        send_cmd(1'b0, 2'd2, 32'h102, 32'h0);
        check("mis_rd_no_m_valid", m_valid, 0);
        tick();
        check("mis_rd_m_valid", m_valid, 0);
        check("mis_rd_rsp_valid", rsp_valid, 1);
        check("mis_rd_rsp_error", rsp_error, 1);
        check("mis_rd_rsp_data", rsp_data, 0);
        check("mis_rd_align_err", align_err, 1);
        send_cmd(1'b1, 2'd1, 32'h101, 32'h0);
        check("mis_wr_no_m_valid", m_valid, 0);
        tick();
        check("mis_wr_m_valid", m_valid, 0);
        check("mis_wr_rsp_valid", rsp_valid, 0);
        check("mis_wr_align_sticky", align_err, 1);
`endif

        // Reset mid-transaction with two commands queued behind the active one
        for (int k = 0; k < 3; k++) send_cmd(1'b1, 2'd2, 32'h600 + 32'(k) * 4, 32'hFFFF0000);
        check("prerst_m_valid", m_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_m_valid", m_valid, 0);
        check("async_rst_m_addr", m_addr, 0);
        check("async_rst_m_wstrb", m_wstrb, 0);
        check("async_rst_cmd_ready", cmd_ready, 0);
        check("async_rst_align_err", align_err, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rerst_rdy_before_edge", cmd_ready, 0);
        tick();
        check("rerst_cmd_ready", cmd_ready, 1);
        check("rerst_m_valid", m_valid, 0);
        tick();
        tick();
        check("rerst_m_valid_later", m_valid, 0);
        check("rerst_rsp_valid", rsp_valid, 0);

        // FIFO really empty: a fresh read is issued next cycle
        send_cmd(1'b0, 2'd2, 32'h700, 32'h0);
        check("post_rst_m_addr", m_addr, 32'h700);
        m_ready = 1'b1;
        m_rdata = 32'h0BADF00D;
        tick();
        m_ready = 1'b0;
        check("post_rst_rsp_data", rsp_data, 32'h0BADF00D);
        check("post_rst_m_valid", m_valid, 0);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
